// File: rtl/psum_lut_decoder.sv
// psum_lut_decoder: converts per-macro partial-sum codes into signed values through a
// lookup table and adds the decoded values of all macros per channel.
// Data moves through two valid/ready register stages (decode, then sum).
// Build option PSUM_DECODER_LUT_PROG_EN: when defined, the table is a register array that
// resets to the default mapping and can be rewritten through lut_we/lut_addr/lut_wdata.
// When undefined, the table is the fixed default mapping and the write ports are ignored.
module psum_lut_decoder #(
    parameter int unsigned CHANNEL_NUM = 128,
    parameter int unsigned MACRO_NUM   = 4,
    parameter int unsigned IN_W        = 5,
    parameter int unsigned OUT_W       = 4,
    parameter int unsigned SUM_W       = OUT_W + $clog2(MACRO_NUM)
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][IN_W-1:0]  data_in,
    input  logic                                             lut_we,
    input  logic [IN_W-1:0]                                  lut_addr,
    input  logic [OUT_W-1:0]                                 lut_wdata,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][OUT_W-1:0] dec_out,
    output logic [CHANNEL_NUM-1:0][SUM_W-1:0]                sum_out
);

    localparam int LutDepth = 2 ** IN_W;
    localparam int DecMax   = (1 << (OUT_W - 1)) - 1;
    localparam int DecMin   = -DecMax - 1;

    typedef logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][OUT_W-1:0] dec_vec_t;
    typedef logic [CHANNEL_NUM-1:0][SUM_W-1:0]                sum_vec_t;

    // Bit-weighted default: bit b of the code contributes b+1 on top of the most
    // negative value, clamped to the signed OUT_W range.
    function automatic logic [OUT_W-1:0] default_entry(input logic [IN_W-1:0] code);
        int acc;
        acc = DecMin;
        for (int b = 0; b < int'(IN_W); b++) begin
            if (code[b]) begin
                acc = acc + b + 1;
            end
        end
        if (acc > DecMax) begin
            acc = DecMax;
        end else if (acc < DecMin) begin
            acc = DecMin;
        end
        return acc[OUT_W-1:0];
    endfunction

    dec_vec_t dec_lookup;

`ifdef PSUM_DECODER_LUT_PROG_EN
    logic [OUT_W-1:0] lut_q [LutDepth];

    // Table storage: reset to the default mapping, one entry rewritten per write.
    // A lookup in the same cycle as a write still sees the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LutDepth; i++) begin
                lut_q[i] <= default_entry(IN_W'(i));
            end
        end else if (lut_we) begin
            lut_q[lut_addr] <= lut_wdata;
        end
    end

    // Look every code up in the shared programmable table.
    always_comb begin
        dec_lookup = '0;
        for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) begin
            for (int m = 0; m < int'(MACRO_NUM); m++) begin
                dec_lookup[ch][m] = lut_q[data_in[ch][m]];
            end
        end
    end
`else
    // Write ports exist for pin compatibility only.
    logic unused_lut_write;
    assign unused_lut_write = ^{lut_we, lut_addr, lut_wdata};

    // Look every code up in the fixed default mapping.
    always_comb begin
        dec_lookup = '0;
        for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) begin
            for (int m = 0; m < int'(MACRO_NUM); m++) begin
                dec_lookup[ch][m] = default_entry(data_in[ch][m]);
            end
        end
    end
`endif

    logic     s1_valid;
    logic     s2_valid;
    logic     s1_load;
    logic     s2_load;
    dec_vec_t s1_dec;
    dec_vec_t s2_dec;
    sum_vec_t s2_sum;
    sum_vec_t sum_next;
    logic signed [SUM_W-1:0] sum_acc;

    // A stage may load when empty or when its contents move on this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Stage valid bits: a loading stage takes the valid of whatever feeds it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Stage 1: register the decoded values on an input transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_dec <= '0;
        end else if (s1_load && in_valid) begin
            s1_dec <= dec_lookup;
        end
    end

    // Per-channel sum of sign-extended decoded values; SUM_W has headroom for all macros.
    always_comb begin
        sum_next = '0;
        sum_acc  = '0;
        for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) begin
            sum_acc = '0;
            for (int m = 0; m < int'(MACRO_NUM); m++) begin
                sum_acc = sum_acc + SUM_W'($signed(s1_dec[ch][m]));
            end
            sum_next[ch] = sum_acc;
        end
    end

    // Stage 2: register decoded values and sums; held while stalled by out_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_dec <= '0;
            s2_sum <= '0;
        end else if (s2_load && s1_valid) begin
            s2_dec <= s1_dec;
            s2_sum <= sum_next;
        end
    end

    assign out_valid = s2_valid;
    assign dec_out   = s2_dec;
    assign sum_out   = s2_sum;

endmodule

// File: tb/tb_psum_lut_decoder.sv
// Self-checking bench for psum_lut_decoder: scoreboard of expected vectors pushed on each
// input transfer and compared whenever the DUT presents a result.
module tb_psum_lut_decoder;

    localparam int CH = 128;
    localparam int M  = 4;
    localparam int IW = 5;
    localparam int OW = 4;
    localparam int SW = 6;

    typedef logic [CH-1:0][M-1:0][IW-1:0] data_t;
    typedef struct {
        logic [CH-1:0][M-1:0][OW-1:0] dec;
        logic [CH-1:0][SW-1:0]        sum;
        int                           acc;
        bit                           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic in_valid;
    logic in_ready;
    data_t data_in;
    logic lut_we;
    logic [IW-1:0] lut_addr;
    logic [OW-1:0] lut_wdata;
    logic out_valid;
    logic out_ready;
    logic [CH-1:0][M-1:0][OW-1:0] dec_out;
    logic [CH-1:0][SW-1:0] sum_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    bit lat_mode = 1'b0;
    exp_t sb[$];
    logic signed [OW-1:0] mdl [2**IW];

    psum_lut_decoder dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dec_out   (dec_out),
        .sum_out   (sum_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Default mapping written straight from its definition.
    function automatic logic [OW-1:0] ref_entry(input int k);
        int v;
        v = -(1 << (OW - 1));
        for (int b = 0; b < IW; b++) begin
            if (k[b]) v = v + b + 1;
        end
        if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
        return v[OW-1:0];
    endfunction

    task automatic init_model();
        for (int i = 0; i < 2**IW; i++) mdl[i] = ref_entry(i);
    endtask

    function automatic data_t rand_vec();
        data_t d;
        for (int ch = 0; ch < CH; ch++)
            for (int m = 0; m < M; m++) d[ch][m] = IW'($urandom_range(0, 2**IW - 1));
        return d;
    endfunction

    function automatic data_t fill_vec(input int code);
        data_t d;
        for (int ch = 0; ch < CH; ch++)
            for (int m = 0; m < M; m++) d[ch][m] = IW'(code);
        return d;
    endfunction

    // Compare presented results with the scoreboard head, then record any new transfer.
    task automatic observe();
        exp_t e;
        int s;
        logic signed [OW-1:0] v;
        cyc++;
        if (out_valid) begin
            check("out_sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb[0];
                for (int ch = 0; ch < CH; ch++) begin
                    check("dec", 64'(dec_out[ch]), 64'(e.dec[ch]));
                    check("sum", 64'(sum_out[ch]), 64'(e.sum[ch]));
                end
                if (out_ready) begin
                    if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
        if (in_valid && in_ready) begin
            for (int ch = 0; ch < CH; ch++) begin
                s = 0;
                for (int m = 0; m < M; m++) begin
                    v = mdl[data_in[ch][m]];
                    e.dec[ch][m] = v;
                    s = s + int'(v);
                end
                e.sum[ch] = s[SW-1:0];
            end
            e.acc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
        end
`ifdef PSUM_DECODER_LUT_PROG_EN
        if (lut_we) mdl[lut_addr] = lut_wdata;
`endif
    endtask

    task automatic drive_cycle(input bit v, input data_t d, input bit ordy, input bit we,
                               input logic [IW-1:0] a, input logic [OW-1:0] wd);
        @(negedge clk);
        in_valid  = v;
        data_in   = d;
        out_ready = ordy;
        lut_we    = we;
        lut_addr  = a;
        lut_wdata = wd;
        #1;
        observe();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        data_t d;
        data_t z;
        int n0;
        bit exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        z = '0;
        rstn = 1'b0;
        in_valid = 1'b0;
        data_in = '0;
        out_ready = 1'b0;
        lut_we = 1'b0;
        lut_addr = '0;
        lut_wdata = '0;
        init_model();
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dec_zero", 64'(|dec_out), 64'd0);
        check("rst_sum_zero", 64'(|sum_out), 64'd0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        // Known codes on channel 0 and code 4 on channel 1.
        lat_mode = 1'b1;
        d = rand_vec();
        d[0][0] = 5'd0;
        d[0][1] = 5'd13;
        d[0][2] = 5'd31;
        d[0][3] = 5'd16;
        d[1][0] = 5'd4;
        drive_cycle(1'b1, d, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("one_cycle_not_valid", 64'(out_valid), 64'd0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("two_cycle_valid", 64'(out_valid), 64'd1);
        check("dec_code0", 64'(dec_out[0][0]), 64'(4'h8));
        check("dec_code13", 64'(dec_out[0][1]), 64'(4'h0));
        check("dec_code31", 64'(dec_out[0][2]), 64'(4'h7));
        check("dec_code16", 64'(dec_out[0][3]), 64'(4'hD));
        check("sum_ch0", 64'(sum_out[0]), 64'(6'h3C));
        check("dec_code4", 64'(dec_out[1][0]), 64'(4'hB));

        // Sweep: every code on every position, back to back.
        n0 = n_out;
        for (int k = 0; k < 32; k++) begin
            for (int ch = 0; ch < CH; ch++)
                for (int m = 0; m < M; m++) d[ch][m] = IW'((k + ch * M + m) % 32);
            drive_cycle(1'b1, d, 1'b1, 1'b0, '0, '0);
        end
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("sweep_count", 64'(n_out - n0), 64'd32);

        // Backpressure: out_ready low for 5 cycles with in_valid high.
        lat_mode = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, rand_vec(), 1'b0, 1'b0, '0, '0);
            check("bp_in_ready", 64'(in_ready), 64'(exp_rdy[i]));
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("bp_delivered", 64'(n_out - n0), 64'd2);
        check("bp_drained", 64'(out_valid), 64'd0);

        lat_mode = 1'b1;
`ifdef PSUM_DECODER_LUT_PROG_EN
        // Write entry 13 in the same cycle a code-13 vector is accepted.
        d = fill_vec(13);
        drive_cycle(1'b1, d, 1'b1, 1'b1, 5'd13, 4'd5);
        drive_cycle(1'b1, d, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("lut_same_cycle_old", 64'(dec_out[0][0]), 64'(4'h0));
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("lut_new_entry", 64'(dec_out[0][0]), 64'(4'h5));
        check("lut_new_sum", 64'(sum_out[0]), 64'(6'h14));
`else
        // Writes are ignored without the programmable table.
        drive_cycle(1'b0, z, 1'b1, 1'b1, 5'd0, 4'h7);
        d = fill_vec(0);
        drive_cycle(1'b1, d, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("lut_write_ignored", 64'(dec_out[0][0]), 64'(4'h8));
        check("lut_ignored_sum", 64'(sum_out[0]), 64'(6'h20));
`endif

        // Reset with both stages full.
        lat_mode = 1'b0;
        drive_cycle(1'b1, rand_vec(), 1'b0, 1'b0, '0, '0);
        drive_cycle(1'b1, rand_vec(), 1'b0, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b0, 1'b0, '0, '0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_dec_zero", 64'(|dec_out), 64'd0);
        check("midrst_sum_zero", 64'(|sum_out), 64'd0);
        sb.delete();
        init_model();
        @(posedge clk);
        #2 rstn = 1'b1;
        lat_mode = 1'b1;
        d = rand_vec();
        d[0][0] = 5'd13;
        drive_cycle(1'b1, d, 1'b1, 1'b0, '0, '0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("post_rst_not_yet", 64'(out_valid), 64'd0);
        drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_code13", 64'(dec_out[0][0]), 64'(4'h0));

        for (int i = 0; i < 3; i++) drive_cycle(1'b0, z, 1'b1, 1'b0, '0, '0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
